// File: rtl/bt_cmd_pkg.sv
// Shared types and constants for the Bluetooth command receiver:
// receiver FSM states, command byte encodings and rx_data bit positions.
package bt_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] CMD_ON_BASE  = 8'h30;
  localparam logic [7:0] CMD_OFF_BASE = 8'h61;
  localparam logic [7:0] CMD_ALL_OFF  = 8'h78;

  localparam logic [3:0] RX_DATA_IDLE = 4'hF;

  localparam logic [1:0] BIT_MOTOR1 = 2'd0;
  localparam logic [1:0] BIT_MOTOR2 = 2'd1;
  localparam logic [1:0] BIT_LUZ    = 2'd2;
  localparam logic [1:0] BIT_SPARE  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-FF input synchronizer, oversampling tick divider and framing FSM.
// byte_strobe/stop_err are single-cycle decodes of the STOP-bit sample tick.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a low sample on a tick
// S_START     | validating start bit at mid-bit
// S_DATA      | sampling 8 data bits LSB first at mid-bit
// S_STOP      | sampling stop bit
// S_WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_core
  import bt_cmd_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       stop_err
);

  localparam int DIV = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] TC_HALF = 4'(OVS / 2 - 1);
  localparam logic [3:0] TC_LAST = 4'(OVS - 1);

  logic          rx_meta, rxs;
  logic [DW-1:0] div_cnt;
  logic          tick;
  rx_state_t     state;
  logic [3:0]    tc;
  logic [2:0]    bi;
  logic [7:0]    shift;
  logic          stop_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tc    <= '0;
      bi    <= '0;
      shift <= '0;
    end else begin
      case (state)
        S_IDLE: if (tick && !rxs) begin
          state <= S_START;
          tc    <= '0;
        end
        S_START: if (tick) begin
          if (tc == TC_HALF) begin
            // a line back high at mid start bit is a glitch, not a frame
            state <= rxs ? S_IDLE : S_DATA;
            tc    <= '0;
            bi    <= '0;
          end else begin
            tc <= tc + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          if (tc == TC_LAST) begin
            shift[bi] <= rxs;
            tc        <= '0;
            if (bi == 3'd7) state <= S_STOP;
            else            bi    <= bi + 3'd1;
          end else begin
            tc <= tc + 4'd1;
          end
        end
        S_STOP: if (tick) begin
          if (tc == TC_LAST) begin
            state <= rxs ? S_IDLE : S_WAIT_HIGH;
            tc    <= '0;
          end else begin
            tc <= tc + 4'd1;
          end
        end
        S_WAIT_HIGH: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stop_sample = (state == S_STOP) && tick && (tc == TC_LAST);
  assign byte_strobe = stop_sample && rxs;
  assign stop_err    = stop_sample && !rxs;
  assign byte_data   = shift;

endmodule

// File: rtl/bt_cmd_receiver.sv
// Bluetooth command receiver: framed bytes from uart_rx_core are decoded into the
// latched active-low actuator word rx_data, with the Motor1/Motor2 interlock.
module bt_cmd_receiver
  import bt_cmd_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] rx_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       cmd_err
);

  logic [7:0] core_byte;
  logic       core_strobe, core_stop_err;
  logic [7:0] off_ofs;
  logic [3:0] dec_next;
  logic       dec_ok;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_data  (core_byte),
    .byte_strobe(core_strobe),
    .stop_err   (core_stop_err)
  );

  assign off_ofs = core_byte - CMD_OFF_BASE;

  always_comb begin
    dec_ok   = 1'b1;
    dec_next = rx_data;
    if (core_byte >= CMD_ON_BASE && core_byte <= CMD_ON_BASE + 8'd3) begin
      dec_next[core_byte[1:0]] = 1'b0;
      // the two motors must never be commanded on together
      if (core_byte[1:0] == BIT_MOTOR1) dec_next[BIT_MOTOR2] = 1'b1;
      if (core_byte[1:0] == BIT_MOTOR2) dec_next[BIT_MOTOR1] = 1'b1;
    end else if (core_byte >= CMD_OFF_BASE && core_byte <= CMD_OFF_BASE + 8'd3) begin
      dec_next[off_ofs[1:0]] = 1'b1;
    end else if (core_byte == CMD_ALL_OFF) begin
      dec_next = RX_DATA_IDLE;
    end else begin
      dec_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= RX_DATA_IDLE;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      byte_valid <= core_strobe;
      frame_err  <= core_stop_err;
      cmd_err    <= core_strobe && !dec_ok;
      if (core_strobe) begin
        rx_byte <= core_byte;
        if (dec_ok) rx_data <= dec_next;
      end
    end
  end

endmodule
